uart_rx_fsm: RTL and testbench
==============================

// Module: uart_rx_fsm
// PURPOSE
//  Sequencing controller for the UART receive path, clocked by the oversampled RX clock.
//  Detects the start edge, owns the edge and bit counters, and pulses the enables for the
//  sampler, deserializer, and start/parity/stop checkers. Qualifies each frame and issues
//  a one-cycle data_valid to the synchronizer.
//  Frame: 1 start, 8 data (LSB first), optional parity, 1 stop.
// PARAMETERS
//  PRESC_W  6  width of Prescale and edge_cnt; supports oversampling up to 32
//  DATA_W   8  data bits per frame; bit_cnt is 4 bits wide
// PORTS
//  CLK          in   1        RX clock (oversampled)
//  RST          in   1        reset; synchronous, active-low
//  RX_IN        in   1        serial line; idle high
//  PAR_EN       in   1        1 = a parity bit follows the data bits
//  Prescale     in   PRESC_W  oversampling ratio; legal values 8, 16, 32 only
//  strt_glitch  in   1        start checker: sampled start bit was 1
//  par_err      in   1        parity checker result
//  stp_err      in   1        stop checker result
//  edge_cnt     out  PRESC_W  oversample position within the current bit
//  bit_cnt      out  4        bit index: 0 start, 1..8 data, 9 parity or stop, 10 stop
//  dat_samp_en  out  1        sampler enable; high in every non-IDLE state
//  deser_en     out  1        one-cycle shift strobe to the deserializer
//  strt_chk_en  out  1        one-cycle strobe to the start checker
//  par_chk_en   out  1        one-cycle strobe to the parity checker
//  stp_chk_en   out  1        one-cycle strobe to the stop checker
//  data_valid   out  1        one-cycle pulse: a good frame is on P_DATA
// BEHAVIOUR
//  Reset (RST=0 at a CLK edge): state=IDLE; all outputs and counters 0. A reset mid-frame
//   aborts the frame; no data_valid is issued for it.
//  Definitions: H=Prescale/2; check point CP = edge_cnt==H+2, the cycle after the 3-sample
//   majority vote at H-1, H, H+1 has settled.
//  Counters: edge_cnt increments every cycle outside IDLE. At Prescale-1 it wraps to 0 and
//   bit_cnt increments.
//  IDLE: RX_IN=0 -> START, edge_cnt<=1, bit_cnt<=0. The detecting cycle counts as edge 0.
//  START: strt_chk_en at CP.
//   - strt_glitch=1 on CP+1 -> IDLE, counters cleared.
//   - Otherwise -> DATA at the bit wrap.
//  DATA: deser_en at CP for each bit_cnt 1..8.
//   - After the wrap out of bit 8: PAR_EN=1 -> PARITY (bit 9); PAR_EN=0 -> STOP (bit 9).
//  PARITY: par_chk_en at CP; par_err on CP+1 latched into err_flag.
//   Always proceeds to STOP (bit 10) so the receiver stays aligned.
//  STOP: stp_chk_en at CP. On CP+1:
//   - data_valid=1 for one cycle iff !stp_err && !err_flag.
//   - Then -> IDLE, counters cleared, err_flag cleared.
//   The return to IDLE at mid-stop allows back-to-back frames with 1 stop bit.
//  PAR_EN and Prescale are sampled only in IDLE; changes mid-frame take effect next frame.
//  Strobes are never asserted in IDLE. At most one strobe is active per cycle.
//  deser_en never coincides with bit_cnt 0, 9 or 10.
//  RX_IN=0 during STOP gives stp_err=1: no data_valid, return to IDLE.
//   RX_IN still low in IDLE is accepted as a new start edge.
// CONFIGURATION
//  UART_RX_FRAME_ERR_CNT_EN defined:
//   - Adds output frame_err_cnt[7:0], reset 0.
//   - +1 on each frame dropped for strt_glitch, par_err or stp_err; saturates at 255.
//  Not defined: port and counter absent; no other behaviour change.
// TESTING
//  1 Prescale=8, PAR_EN=0, frame 0xA5: deser_en exactly 8 pulses, bit_cnt 1..8;
//    data_valid=1 once, 79 CLK after the IDLE start detect.
//  2 Prescale=16, PAR_EN=1, frame 0x3C with correct parity: one par_chk_en pulse at
//    bit_cnt 9; data_valid once, at bit_cnt 10.
//  3 Prescale=8, start glitch (RX_IN low 2 cycles only): strt_glitch -> IDLE;
//    no deser_en, no data_valid; frame_err_cnt=1 when the macro is defined.
//  4 Prescale=32, PAR_EN=1, wrong parity: stp_chk_en still pulses; data_valid stays 0;
//    next frame 0x55 is received OK.
//  5 Prescale=8, two back-to-back frames 0x01 then 0xFF: two data_valid pulses,
//    none missed.
//  6 RST=0 asserted at bit_cnt 4 of a frame: the next cycle has all outputs 0 and state
//    IDLE; no data_valid for the aborted frame.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: sequencing controller for the UART receive path.
// Runs on the oversampled RX clock, tracks the oversample position (edge_cnt)
// and bit index (bit_cnt) of the current frame, strobes the sampler-side
// helpers at the mid-bit check point and qualifies each frame with data_valid.
// Optional feature: define UART_RX_FRAME_ERR_CNT_EN to add a saturating
// frame_err_cnt output counting dropped frames.
module uart_rx_fsm #(
  parameter int PRESC_W = 6,
  parameter int DATA_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
`ifdef UART_RX_FRAME_ERR_CNT_EN
  ,
  output logic [7:0]         frame_err_cnt
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Index of the last data bit; bit 0 is the start bit.
  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_W);

  logic [2:0]         state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [3:0]         bit_q, bit_d;
  logic               par_en_q, par_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               err_flag_q, err_flag_d;

  // Frame timing is derived from the prescale captured at the start edge,
  // so a Prescale change mid-frame cannot misalign the current frame.
  logic [PRESC_W-1:0] half_pos;
  logic [PRESC_W-1:0] cp_pos;
  logic [PRESC_W-1:0] cp1_pos;
  logic [PRESC_W-1:0] wrap_pos;
  logic               at_cp;
  logic               at_cp1;
  logic               at_wrap;

  assign half_pos = presc_q >> 1;
  // The 3-sample vote uses H-1..H+1; the checkers are strobed one cycle
  // after the vote has settled, and report back the cycle after that.
  assign cp_pos   = half_pos + PRESC_W'(2);
  assign cp1_pos  = half_pos + PRESC_W'(3);
  assign wrap_pos = presc_q - PRESC_W'(1);
  assign at_cp    = (edge_q == cp_pos);
  assign at_cp1   = (edge_q == cp1_pos);
  assign at_wrap  = (edge_q == wrap_pos);

  // Next-state logic: counters advance every non-IDLE cycle, the FSM moves
  // on bit wraps and returns to IDLE early on a glitch or at mid-stop.
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    par_en_d   = par_en_q;
    presc_d    = presc_q;
    err_flag_d = err_flag_q;

    if (state_q != IDLE) begin
      if (at_wrap) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PRESC_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          // The detecting cycle is edge 0, so the next one is edge 1.
          state_d    = START;
          edge_d     = PRESC_W'(1);
          bit_d      = '0;
          par_en_d   = PAR_EN;
          presc_d    = Prescale;
          err_flag_d = 1'b0;
        end
      end
      START: begin
        if (at_cp1 && strt_glitch) begin
          state_d    = IDLE;
          edge_d     = '0;
          bit_d      = '0;
          err_flag_d = 1'b0;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_wrap && (bit_q == LAST_DATA_BIT)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        // A parity error only poisons the frame; the stop bit is still
        // tracked so the receiver stays aligned with the line.
        if (at_cp1) begin
          err_flag_d = par_err;
        end
        if (at_wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a following start bit be caught even
        // with a single stop bit between frames.
        if (at_cp1) begin
          state_d    = IDLE;
          edge_d     = '0;
          bit_d      = '0;
          err_flag_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_d     = '0;
        bit_d      = '0;
        err_flag_d = 1'b0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      presc_q    <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      par_en_q   <= par_en_d;
      presc_q    <= presc_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Output decode: every strobe is qualified by its own state, so none can
  // fire in IDLE and at most one is active in any cycle.
  always_comb begin
    edge_cnt    = edge_q;
    bit_cnt     = bit_q;
    dat_samp_en = (state_q != IDLE);
    strt_chk_en = (state_q == START)  && at_cp;
    deser_en    = (state_q == DATA)   && at_cp;
    par_chk_en  = (state_q == PARITY) && at_cp;
    stp_chk_en  = (state_q == STOP)   && at_cp;
    data_valid  = (state_q == STOP)   && at_cp1 && !stp_err && !err_flag_q;
  end

`ifdef UART_RX_FRAME_ERR_CNT_EN
  logic       frame_drop;
  logic [7:0] err_cnt_q, err_cnt_d;

  // A frame is dropped exactly once: at its start-glitch decision or at
  // its stop decision, both of which happen on the cycle after the check.
  assign frame_drop = at_cp1 &&
                      (((state_q == START) && strt_glitch) ||
                       ((state_q == STOP) && (stp_err || err_flag_q)));

  assign err_cnt_d = (frame_drop && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  // Saturating dropped-frame counter.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign frame_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: drives a serial line sample by sample, models
// the start/parity/stop checkers and the deserializer around the DUT, and
// checks strobe counts, positions, captured bytes and frame latency.
module tb_uart_rx_fsm;

  localparam int PRESC_W = 6;

  localparam int M_GOOD    = 0;
  localparam int M_GLITCH  = 1;
  localparam int M_BADPAR  = 2;
  localparam int M_BADSTOP = 3;

  logic               CLK = 1'b0;
  logic               RST;
  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] Prescale;
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;
  logic [PRESC_W-1:0] edge_cnt;
  logic [3:0]         bit_cnt;
  logic               dat_samp_en;
  logic               deser_en;
  logic               strt_chk_en;
  logic               par_chk_en;
  logic               stp_chk_en;
  logic               data_valid;
`ifdef UART_RX_FRAME_ERR_CNT_EN
  logic [7:0]         frame_err_cnt;
`endif

  always #5 CLK = ~CLK;

  uart_rx_fsm #(.PRESC_W(PRESC_W), .DATA_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid)
`ifdef UART_RX_FRAME_ERR_CNT_EN
    ,
    .frame_err_cnt (frame_err_cnt)
`endif
  );

  typedef struct {
    int         presc;
    logic       par_en;
    logic [7:0] data;
    int         mode;
    int         exp_valid;
    int         exp_deser;
    int         exp_par;
    int         exp_stp;
    int         exp_lat;
    int         exp_vbit;
    int         exp_drop;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int tick_n = 0;
  int exp_errcnt = 0;

  int n_deser, n_valid, n_strt, n_par, n_stp, viol;
  int valid_tick, valid_bit, par_bit;
  logic [7:0] shreg;
  logic [7:0] valid_q[$];
  logic       line_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_deser = 0; n_valid = 0; n_strt = 0; n_par = 0; n_stp = 0; viol = 0;
    valid_tick = -1; valid_bit = -1; par_bit = -1;
    shreg = '0;
    valid_q.delete();
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  // One clock: apply line sample, observe DUT, update checker models.
  task automatic tick(input logic rx);
    int strobes;
    @(negedge CLK);
    RX_IN = rx;
    tick_n++;
    strobes = int'(deser_en) + int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en);
    if (strobes > 1) viol++;
    if (!dat_samp_en && (strobes != 0 || data_valid)) viol++;
    if (data_valid) begin
      n_valid++;
      valid_tick = tick_n;
      valid_bit  = int'(bit_cnt);
      valid_q.push_back(shreg);
    end
    if (deser_en) begin
      if (int'(bit_cnt) != (n_deser % 8) + 1) viol++;
      n_deser++;
      shreg = {RX_IN, shreg[7:1]};
    end
    if (strt_chk_en) begin
      n_strt++;
      strt_glitch = RX_IN;
    end
    if (par_chk_en) begin
      n_par++;
      par_bit = int'(bit_cnt);
      par_err = (RX_IN != ^shreg);
    end
    if (stp_chk_en) begin
      n_stp++;
      stp_err = !RX_IN;
    end
  endtask

  task automatic build_frame(input int p, input logic pe, input logic [7:0] d, input int mode, input int gap);
    for (int e = 0; e < p; e++) line_q.push_back((mode == M_GLITCH) ? (e >= 2) : 1'b0);
    if (mode != M_GLITCH) begin
      for (int b = 0; b < 8; b++)
        for (int e = 0; e < p; e++) line_q.push_back(d[b]);
      if (pe)
        for (int e = 0; e < p; e++) line_q.push_back((^d) ^ (mode == M_BADPAR));
      for (int e = 0; e < p; e++) line_q.push_back(mode != M_BADSTOP);
    end
    for (int e = 0; e < gap; e++) line_q.push_back(1'b1);
  endtask

  task automatic play(output int start_tick);
    start_tick = tick_n + 1;
    while (line_q.size() > 0) tick(line_q.pop_front());
  endtask

  task automatic check_errcnt(input string name);
`ifdef UART_RX_FRAME_ERR_CNT_EN
    check(name, frame_err_cnt, exp_errcnt);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  vec_t vecs[6];
  int   st;
  logic [7:0] b0, b1;

  initial begin
    //         presc par data   mode      val des par stp lat  vbit drop
    vecs[0] = '{8,  1'b0, 8'hA5, M_GOOD,   1, 8, 0, 1, 79,  9,  0};
    vecs[1] = '{16, 1'b1, 8'h3C, M_GOOD,   1, 8, 1, 1, 171, 10, 0};
    vecs[2] = '{8,  1'b0, 8'h00, M_GLITCH, 0, 0, 0, 0, 0,   0,  1};
    vecs[3] = '{32, 1'b1, 8'h96, M_BADPAR, 0, 8, 1, 1, 0,   0,  1};
    vecs[4] = '{32, 1'b1, 8'h55, M_GOOD,   1, 8, 1, 1, 339, 10, 0};
    vecs[5] = '{8,  1'b1, 8'h00, M_GOOD,   1, 8, 1, 1, 87,  10, 0};

    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    clear_mon();
    repeat (3) tick(1'b1);
    check("rst_edge_cnt", edge_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_samp_en", dat_samp_en, 0);
    check("rst_strobes", {deser_en, strt_chk_en, par_chk_en, stp_chk_en}, 0);
    check("rst_data_valid", data_valid, 0);
    check_errcnt("rst_err_cnt");
    RST = 1'b1;
    repeat (4) tick(1'b1);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      Prescale = 6'(vecs[i].presc);
      PAR_EN   = vecs[i].par_en;
      build_frame(vecs[i].presc, vecs[i].par_en, vecs[i].data, vecs[i].mode, 3 * vecs[i].presc);
      play(st);
      exp_errcnt += vecs[i].exp_drop;
      $display("vec %0d: presc=%0d par=%0d data=0x%02h mode=%0d valid=%0d deser=%0d",
               i, vecs[i].presc, vecs[i].par_en, vecs[i].data, vecs[i].mode, n_valid, n_deser);
      check($sformatf("v%0d_valid", i), n_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_deser", i), n_deser, vecs[i].exp_deser);
      check($sformatf("v%0d_par", i), n_par, vecs[i].exp_par);
      check($sformatf("v%0d_stp", i), n_stp, vecs[i].exp_stp);
      check($sformatf("v%0d_strt", i), n_strt, 1);
      check($sformatf("v%0d_invariants", i), viol, 0);
      if (vecs[i].exp_valid > 0) begin
        check($sformatf("v%0d_byte", i), valid_q[0], vecs[i].data);
        check($sformatf("v%0d_latency", i), valid_tick - st, vecs[i].exp_lat);
        check($sformatf("v%0d_valid_bit", i), valid_bit, vecs[i].exp_vbit);
      end
      if (vecs[i].exp_par > 0) check($sformatf("v%0d_par_bit", i), par_bit, 9);
      check_errcnt($sformatf("v%0d_err_cnt", i));
    end

    // Stop bit held low at Prescale=16: frame dropped, and the still-low
    // line after mid-stop is taken as a new start that then glitches out.
    clear_mon();
    Prescale = 6'd16; PAR_EN = 1'b0;
    build_frame(16, 1'b0, 8'hC3, M_BADSTOP, 48);
    play(st);
    exp_errcnt += 2;
    $display("badstop: valid=%0d strt=%0d stp=%0d", n_valid, n_strt, n_stp);
    check("badstop_valid", n_valid, 0);
    check("badstop_restart", n_strt, 2);
    check("badstop_stp", n_stp, 1);
    check("badstop_invariants", viol, 0);
    check_errcnt("badstop_err_cnt");

    // Back-to-back frames, one stop bit, no idle gap.
    clear_mon();
    Prescale = 6'd8; PAR_EN = 1'b0;
    build_frame(8, 1'b0, 8'h01, M_GOOD, 0);
    build_frame(8, 1'b0, 8'hFF, M_GOOD, 24);
    play(st);
    $display("b2b: valid=%0d deser=%0d", n_valid, n_deser);
    check("b2b_valid", n_valid, 2);
    check("b2b_deser", n_deser, 16);
    b0 = (valid_q.size() > 0) ? valid_q[0] : 8'hxx;
    b1 = (valid_q.size() > 1) ? valid_q[1] : 8'hxx;
    check("b2b_byte0", b0, 8'h01);
    check("b2b_byte1", b1, 8'hFF);
    check("b2b_latency2", valid_tick - st, 159);
    check("b2b_invariants", viol, 0);

    // Reset in the middle of data bit 4.
    clear_mon();
    Prescale = 6'd8; PAR_EN = 1'b0;
    build_frame(8, 1'b0, 8'h5A, M_GOOD, 0);
    for (int i = 0; i < 36; i++) tick(line_q.pop_front());
    line_q.delete();
    check("abort_bit_cnt", bit_cnt, 4);
    check("abort_edge_cnt", edge_cnt, 3);
    RST = 1'b0;
    tick(1'b1);
    RST = 1'b1;
    exp_errcnt = 0;
    $display("abort: edge=%0d bit=%0d samp=%0d", edge_cnt, bit_cnt, dat_samp_en);
    check("abort_outputs_zero",
          {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}, 0);
    repeat (120) tick(1'b1);
    check("abort_no_valid", n_valid, 0);
    check("abort_idle", dat_samp_en, 0);
    check_errcnt("abort_err_cnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
